// File: rtl/slv_guard_rst_seq_pkg.sv
// Shared types and default constants for the subordinate-guard reset sequencer.
package slv_pkg;

  localparam int DefRstHoldCycles = 16;
  localparam int DefAckTimeout    = 255;
  localparam int DefRetryMax      = 2;
  localparam int DefCntWidth      = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ASSERT   = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_FAIL     = 3'd4;

  typedef enum logic [2:0] {
    RS_IDLE     = ST_IDLE,
    RS_ASSERT   = ST_ASSERT,
    RS_WAIT_ACK = ST_WAIT_ACK,
    RS_DONE     = ST_DONE,
    RS_FAIL     = ST_FAIL
  } rst_seq_state_e;

  // Largest value the shared down-counter is ever loaded with.
  function automatic int cnt_max_load(input int hold_cycles, input int ack_timeout);
    int a;
    int b;
    a = hold_cycles - 1;
    b = ack_timeout - 1;
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slv_guard_rst_seq.sv
// Reset sequencer behind the subordinate guard: holds the subordinate in reset,
// waits for its ready acknowledge, retries on timeout and parks it on failure.
module slv_guard_rst_seq
  import slv_pkg::*;
#(
  parameter int RstHoldCycles = DefRstHoldCycles,
  parameter int AckTimeout    = DefAckTimeout,
  parameter int RetryMax      = DefRetryMax,
  parameter int CntWidth      = DefCntWidth,
  localparam int RetryW       = (RetryMax > 0) ? $clog2(RetryMax + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rst_req_i,
  output logic              slv_rst_no,
  input  logic              slv_rst_ack_i,
  output logic              rst_stat_o,
  output logic              busy_o,
  output logic              fail_o,
  output logic [RetryW-1:0] retry_cnt_o,
  input  logic              clr_fail_i
);

  if (RstHoldCycles < 1) begin : g_bad_hold
    $error("RstHoldCycles must be at least 1");
  end
  if (AckTimeout < 1) begin : g_bad_timeout
    $error("AckTimeout must be at least 1");
  end
  if ((64'(cnt_max_load(RstHoldCycles, AckTimeout)) >> CntWidth) != 64'd0) begin : g_bad_cnt
    $error("CntWidth too small for RstHoldCycles/AckTimeout");
  end

  localparam logic [CntWidth-1:0] HoldLoad = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0] AckLoad  = CntWidth'(AckTimeout - 1);

  rst_seq_state_e    r_state;
  logic [CntWidth-1:0] r_cnt;
  logic [RetryW-1:0] r_retry;
  logic              r_req_q;
  logic              r_slv_rst_n;
  logic              r_rst_stat;
  logic              r_fail;

  rst_seq_state_e    w_state_d;
  logic [CntWidth-1:0] w_cnt_d;
  logic [RetryW-1:0] w_retry_d;
  logic              w_trig;
  logic              w_cnt_zero;

  // Edge detect: a request held high across a whole sequence fires only once.
  assign w_trig     = rst_req_i & ~r_req_q;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_retry_d = r_retry;
    unique case (r_state)
      RS_IDLE: begin
        if (w_trig) begin
          w_state_d = RS_ASSERT;
          w_cnt_d   = HoldLoad;
          w_retry_d = '0;
        end
      end
      RS_ASSERT: begin
        if (w_cnt_zero) begin
          w_state_d = RS_WAIT_ACK;
          w_cnt_d   = AckLoad;
        end else begin
          w_cnt_d = r_cnt - CntWidth'(1);
        end
      end
      RS_WAIT_ACK: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (slv_rst_ack_i) begin
          w_state_d = RS_DONE;
          w_cnt_d   = '0;
        end else if (w_cnt_zero) begin
          if (int'(r_retry) < RetryMax) begin
            w_state_d = RS_ASSERT;
            w_cnt_d   = HoldLoad;
            w_retry_d = r_retry + RetryW'(1);
          end else begin
            w_state_d = RS_FAIL;
            w_cnt_d   = '0;
          end
        end else begin
          w_cnt_d = r_cnt - CntWidth'(1);
        end
      end
      RS_DONE: begin
        w_state_d = RS_IDLE;
      end
      RS_FAIL: begin
        if (clr_fail_i) begin
          w_state_d = RS_IDLE;
          w_retry_d = '0;
        end
      end
      default: begin
        w_state_d = RS_IDLE;
        w_cnt_d   = '0;
        w_retry_d = '0;
      end
    endcase
  end

  // Outputs are flopped from the next state so they align with r_state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= RS_IDLE;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_req_q     <= 1'b0;
      r_slv_rst_n <= 1'b1;
      r_rst_stat  <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_retry     <= w_retry_d;
      r_req_q     <= rst_req_i;
      r_slv_rst_n <= !((w_state_d == RS_ASSERT) || (w_state_d == RS_FAIL));
      r_rst_stat  <= (w_state_d == RS_DONE);
      r_fail      <= (w_state_d == RS_FAIL);
    end
  end

  assign slv_rst_no  = r_slv_rst_n;
  assign rst_stat_o  = r_rst_stat;
  assign fail_o      = r_fail;
  assign busy_o      = (r_state != RS_IDLE);
  assign retry_cnt_o = r_retry;

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Directed bench for slv_guard_rst_seq with RstHoldCycles=4, AckTimeout=8, RetryMax=2.
module tb_slv_guard_rst_seq;

  localparam int Hold  = 4;
  localparam int Tmo   = 8;
  localparam int RMax  = 2;
  localparam int CW    = 8;
  localparam int RW    = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          rst_req_i;
  logic          slv_rst_no;
  logic          slv_rst_ack_i;
  logic          rst_stat_o;
  logic          busy_o;
  logic          fail_o;
  logic [RW-1:0] retry_cnt_o;
  logic          clr_fail_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_stat   = 0;
  int n_low    = 0;
  int n_pulse  = 0;
  logic prev_slv_n = 1'b1;

  always #5 clk = ~clk;

  slv_guard_rst_seq #(
    .RstHoldCycles(Hold),
    .AckTimeout   (Tmo),
    .RetryMax     (RMax),
    .CntWidth     (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rst_req_i    (rst_req_i),
    .slv_rst_no   (slv_rst_no),
    .slv_rst_ack_i(slv_rst_ack_i),
    .rst_stat_o   (rst_stat_o),
    .busy_o       (busy_o),
    .fail_o       (fail_o),
    .retry_cnt_o  (retry_cnt_o),
    .clr_fail_i   (clr_fail_i)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample outputs 1 time unit later and update monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_stat_o) n_stat++;
    if (!slv_rst_no) n_low++;
    if (prev_slv_n && !slv_rst_no) n_pulse++;
    prev_slv_n = slv_rst_no;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    n_stat  = 0;
    n_low   = 0;
    n_pulse = 0;
  endtask

  task automatic trigger();
    rst_req_i = 1'b1;
    tick();
    rst_req_i = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    rst_req_i     = 1'b0;
    slv_rst_ack_i = 1'b0;
    clr_fail_i    = 1'b0;
    ticks(2);
    check_val("rst_slv_rst_n", 32'(slv_rst_no), 32'd1);
    check_val("rst_stat", 32'(rst_stat_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_fail", 32'(fail_o), 32'd0);
    check_val("rst_retry", 32'(retry_cnt_o), 32'd0);
    rst_ni = 1'b1;
    ticks(3);

    // Nominal sequence, ack on the first WAIT_ACK cycle.
    clear_counts();
    trigger();
    check_val("nom_busy_start", 32'(busy_o), 32'd1);
    check_val("nom_slv_low_start", 32'(slv_rst_no), 32'd0);
    ticks(3);
    check_val("nom_slv_low_last", 32'(slv_rst_no), 32'd0);
    tick();
    check_val("nom_slv_released", 32'(slv_rst_no), 32'd1);
    check_val("nom_stat_not_yet", 32'(rst_stat_o), 32'd0);
    slv_rst_ack_i = 1'b1;
    tick();
    slv_rst_ack_i = 1'b0;
    check_val("nom_stat_pulse", 32'(rst_stat_o), 32'd1);
    check_val("nom_retry", 32'(retry_cnt_o), 32'd0);
    tick();
    check_val("nom_stat_end", 32'(rst_stat_o), 32'd0);
    check_val("nom_busy_end", 32'(busy_o), 32'd0);
    check_val("nom_low_cycles", 32'(n_low), 32'd4);
    check_val("nom_stat_count", 32'(n_stat), 32'd1);
    ticks(2);

    // Held request with ack held high throughout: one sequence, ack ignored in ASSERT.
    clear_counts();
    rst_req_i     = 1'b1;
    slv_rst_ack_i = 1'b1;
    ticks(30);
    check_val("held_pulses", 32'(n_pulse), 32'd1);
    check_val("held_low_cycles", 32'(n_low), 32'd4);
    check_val("held_stat_count", 32'(n_stat), 32'd1);
    check_val("held_busy", 32'(busy_o), 32'd0);
    rst_req_i     = 1'b0;
    slv_rst_ack_i = 1'b0;
    ticks(2);

    // Single retry: ack given 3 cycles into the second WAIT_ACK.
    clear_counts();
    trigger();
    ticks(11);
    check_val("retry_wait_last", 32'(slv_rst_no), 32'd1);
    check_val("retry_cnt_first", 32'(retry_cnt_o), 32'd0);
    tick();
    check_val("retry_reassert", 32'(slv_rst_no), 32'd0);
    check_val("retry_cnt_one", 32'(retry_cnt_o), 32'd1);
    ticks(6);
    check_val("retry_wait2", 32'(slv_rst_no), 32'd1);
    slv_rst_ack_i = 1'b1;
    tick();
    slv_rst_ack_i = 1'b0;
    check_val("retry_stat_pulse", 32'(rst_stat_o), 32'd1);
    tick();
    check_val("retry_busy_end", 32'(busy_o), 32'd0);
    check_val("retry_cnt_kept", 32'(retry_cnt_o), 32'd1);
    check_val("retry_pulses", 32'(n_pulse), 32'd2);
    check_val("retry_low_cycles", 32'(n_low), 32'd8);
    check_val("retry_stat_count", 32'(n_stat), 32'd1);
    ticks(2);

    // Failure: no ack ever, three attempts then FAIL.
    clear_counts();
    trigger();
    ticks(35);
    check_val("fail_pre_slv", 32'(slv_rst_no), 32'd1);
    check_val("fail_pre_flag", 32'(fail_o), 32'd0);
    check_val("fail_pre_pulses", 32'(n_pulse), 32'd3);
    check_val("fail_pre_low", 32'(n_low), 32'd12);
    tick();
    check_val("fail_flag", 32'(fail_o), 32'd1);
    check_val("fail_slv_parked", 32'(slv_rst_no), 32'd0);
    check_val("fail_retry", 32'(retry_cnt_o), 32'd2);
    trigger();
    ticks(4);
    check_val("fail_still", 32'(fail_o), 32'd1);
    check_val("fail_no_stat", 32'(n_stat), 32'd0);
    clr_fail_i = 1'b1;
    tick();
    clr_fail_i = 1'b0;
    check_val("clr_fail_flag", 32'(fail_o), 32'd0);
    check_val("clr_slv", 32'(slv_rst_no), 32'd1);
    check_val("clr_busy", 32'(busy_o), 32'd0);
    check_val("clr_retry", 32'(retry_cnt_o), 32'd0);
    ticks(2);

    // Ack on the timeout-expiry cycle wins over retry.
    clear_counts();
    trigger();
    ticks(11);
    slv_rst_ack_i = 1'b1;
    tick();
    slv_rst_ack_i = 1'b0;
    check_val("edge_ack_stat", 32'(rst_stat_o), 32'd1);
    check_val("edge_ack_retry", 32'(retry_cnt_o), 32'd0);
    check_val("edge_ack_slv", 32'(slv_rst_no), 32'd1);
    tick();
    check_val("edge_ack_pulses", 32'(n_pulse), 32'd1);
    ticks(2);

    // Second request edge during ASSERT is ignored.
    clear_counts();
    trigger();
    tick();
    rst_req_i = 1'b1;
    tick();
    rst_req_i     = 1'b0;
    slv_rst_ack_i = 1'b1;
    ticks(10);
    slv_rst_ack_i = 1'b0;
    check_val("dup_req_stat", 32'(n_stat), 32'd1);
    check_val("dup_req_pulses", 32'(n_pulse), 32'd1);
    check_val("dup_req_busy", 32'(busy_o), 32'd0);

    // Mid-sequence reset during ASSERT.
    clear_counts();
    trigger();
    ticks(2);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_val("midrst_slv", 32'(slv_rst_no), 32'd1);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_fail", 32'(fail_o), 32'd0);
    check_val("midrst_stat", 32'(rst_stat_o), 32'd0);
    slv_rst_ack_i = 1'b1;
    ticks(10);
    slv_rst_ack_i = 1'b0;
    check_val("midrst_no_stat", 32'(n_stat), 32'd0);
    check_val("midrst_idle", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
